// File: rtl/branch_pkg.sv
// Shared types and constants for the EightyTwos PC sequencer: FSM states,
// jump condition codes and flag bit positions.
package branch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [2:0] COND_ALWAYS = 3'b000;
   localparam logic [2:0] COND_ZERO   = 3'b001;
   localparam logic [2:0] COND_NC     = 3'b010;
   localparam logic [2:0] COND_CARRY  = 3'b011;
   localparam logic [2:0] COND_PO     = 3'b100;
   localparam logic [2:0] COND_PE     = 3'b101;
   localparam logic [2:0] COND_PLUS   = 3'b111;
   localparam logic [2:0] COND_MINUS  = 3'b110;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_P = 2;
   localparam int unsigned FLAG_Z = 6;
   localparam int unsigned FLAG_S = 7;

   // A zero length field is a 1-byte instruction.
   function automatic logic [1:0] eff_len(input logic [1:0] len);
      return (len == 2'd0) ? 2'd1 : len;
   endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and memory (slave).
interface branch_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic              fetch_valid;
   logic              fetch_ready;
   logic [ADDR_W-1:0] pc;

   modport master (output fetch_valid, output pc, input fetch_ready);
   modport slave  (input fetch_valid, input pc, output fetch_ready);
endinterface

// File: rtl/branch_sequencer_cond_eval.sv
// Jump condition evaluator: decides whether a jump is taken from the flag
// register, the condition code and the unconditional qualifier.
module cond_eval
   import branch_pkg::*;
(
   input  logic [7:0] flags,
   input  logic [2:0] cond,
   input  logic       uncond,
   output logic       take
);

   // Flag bits not used by any condition.
   logic unused_flag_bits;
   assign unused_flag_bits = ^{flags[5:3], flags[1]};

   // NOTE: every always_comb output gets a default before the case so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      take = 1'b0;
      case (cond)
         COND_ALWAYS: take = uncond;
         COND_ZERO:   take = flags[FLAG_Z];
         COND_NC:     take = ~flags[FLAG_C];
         COND_CARRY:  take = flags[FLAG_C];
         COND_PO:     take = ~flags[FLAG_P];
         COND_PE:     take = flags[FLAG_P];
         COND_MINUS:  take = flags[FLAG_S];
         COND_PLUS:   take = ~flags[FLAG_S];
         default:     take = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: owns the PC, the flag register and the
// fetch/execute/halt state machine.
module branch_sequencer
   import branch_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   branch_sequencer_if.master  fetch,
   input  logic [7:0]          flags_in,
   input  logic                flags_we,
   input  logic                retire,
   input  logic [1:0]          instr_len,
   input  logic                br_valid,
   input  logic [2:0]          br_cond,
   input  logic                br_always,
   input  logic [ADDR_W-1:0]   br_target,
   input  logic                halt_req,
   input  logic                resume,
   output logic                halted,
   output logic                jump_taken,
   output logic [7:0]          flags
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic              cond_take;
   logic              take_jump;

   cond_eval u_cond_eval (
      .flags  (flags),
      .cond   (br_cond),
      .uncond (br_always),
      .take   (cond_take)
   );

   assign fetch.pc          = pc_q;
   assign fetch.fetch_valid = (state == FETCH) && !rst;
   assign halted            = (state == HALT);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      take_jump = 1'b0;
      unique case (state)
         FETCH: begin
            // A completed handshake beats a simultaneous halt request.
            if (fetch.fetch_ready)
               state_nxt = EXEC;
            else if (halt_req)
               state_nxt = HALT;
         end
         EXEC: begin
            if (retire) begin
               // cond_take reads the registered flags, so a same-edge
               // flags_we cannot influence this jump.
               if (br_valid && cond_take) begin
                  pc_nxt    = br_target;
                  take_jump = 1'b1;
               end else begin
                  pc_nxt = pc_q + ADDR_W'(eff_len(instr_len));
               end
               state_nxt = halt_req ? HALT : FETCH;
            end
         end
         HALT: begin
            if (resume && !halt_req)
               state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc_q       <= RESET_PC;
         flags      <= 8'h00;
         jump_taken <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc_q       <= pc_nxt;
         jump_taken <= take_jump;
         if (flags_we)
            flags <= flags_in;
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed vector table, corner
// sequences, then randomized stimulus against a behavioural model.
module tb_branch_sequencer;

   localparam logic [15:0] RST_PC = 16'h0100;

   logic        clk;
   logic        rst;
   logic [7:0]  flags_in;
   logic        flags_we;
   logic        retire;
   logic [1:0]  instr_len;
   logic        br_valid;
   logic [2:0]  br_cond;
   logic        br_always;
   logic [15:0] br_target;
   logic        halt_req;
   logic        resume;
   logic        halted;
   logic        jump_taken;
   logic [7:0]  flags;

   int errors = 0;
   int checks = 0;

   branch_sequencer_if #(.ADDR_W(16)) bus ();

   branch_sequencer #(.ADDR_W(16), .RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch      (bus),
      .flags_in   (flags_in),
      .flags_we   (flags_we),
      .retire     (retire),
      .instr_len  (instr_len),
      .br_valid   (br_valid),
      .br_cond    (br_cond),
      .br_always  (br_always),
      .br_target  (br_target),
      .halt_req   (halt_req),
      .resume     (resume),
      .halted     (halted),
      .jump_taken (jump_taken),
      .flags      (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flags_we  = 1'b0; flags_in = 8'h00; bus.fetch_ready = 1'b0;
      retire    = 1'b0; instr_len = 2'd0; br_valid = 1'b0;
      br_cond   = 3'b000; br_always = 1'b0; br_target = 16'h0000;
      halt_req  = 1'b0; resume = 1'b0;
   endtask

   // Directed vectors: inputs applied for one edge, outputs expected after it.
   typedef struct {
      logic        fwe;  logic [7:0] fin; logic rdy; logic ret; logic [1:0] len;
      logic        bv;   logic [2:0] bc;  logic ba;  logic [15:0] tgt;
      logic        hr;   logic res;
      logic [15:0] e_pc; logic e_fv; logic e_jt; logic e_h; logic [7:0] e_fl;
   } vec_t;

   vec_t vecs [23];

   // Behavioural model, written from the architectural rules.
   typedef enum {M_WAIT, M_BUSY, M_STOP} mmode_t;
   mmode_t     m_mode;
   int         m_pc;
   logic [7:0] m_flags;
   logic       m_jt;

   function automatic logic cond_holds(input logic [7:0] f, input logic [2:0] code, input logic alw);
      logic [7:0] truth;
      truth = {~f[7], f[7], f[2], ~f[2], f[0], ~f[0], f[6], alw};
      return truth[code];
   endfunction

   task automatic model_edge();
      int l;
      if (rst) begin
         m_mode = M_WAIT; m_pc = int'(RST_PC); m_flags = 8'h00; m_jt = 1'b0;
         return;
      end
      m_jt = 1'b0;
      case (m_mode)
         M_WAIT: if (bus.fetch_ready) m_mode = M_BUSY; else if (halt_req) m_mode = M_STOP;
         M_BUSY: if (retire) begin
            if (br_valid && cond_holds(m_flags, br_cond, br_always)) begin
               m_pc = int'(br_target); m_jt = 1'b1;
            end else begin
               l = (instr_len == 2'd0) ? 1 : int'(instr_len);
               m_pc = (m_pc + l) % 65536;
            end
            m_mode = halt_req ? M_STOP : M_WAIT;
         end
         M_STOP: if (resume && !halt_req) m_mode = M_WAIT;
         default: m_mode = M_WAIT;
      endcase
      if (flags_we) m_flags = flags_in;
   endtask

   initial begin
      logic [26:0] act, exp;

      //            fwe fin   rdy ret len  bv bc ba tgt       hr res | pc       fv jt h  fl
      vecs[0]  = '{0, 8'h00, 1, 1, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0100, 0, 0, 0, 8'h00};
      vecs[1]  = '{0, 8'h00, 1, 1, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0102, 1, 0, 0, 8'h00};
      vecs[2]  = '{0, 8'h00, 1, 1, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0102, 0, 0, 0, 8'h00};
      vecs[3]  = '{0, 8'h00, 1, 1, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0104, 1, 0, 0, 8'h00};
      vecs[4]  = '{1, 8'h40, 1, 0, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0104, 0, 0, 0, 8'h40};
      vecs[5]  = '{0, 8'h00, 1, 1, 2'd2, 1, 3'd1, 0, 16'h2000, 0, 0, 16'h2000, 1, 1, 0, 8'h40};
      vecs[6]  = '{1, 8'h00, 1, 0, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h2000, 0, 0, 0, 8'h00};
      vecs[7]  = '{0, 8'h00, 1, 1, 2'd3, 1, 3'd1, 0, 16'h3000, 0, 0, 16'h2003, 1, 0, 0, 8'h00};
      vecs[8]  = '{0, 8'h00, 1, 0, 2'd3, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h2003, 0, 0, 0, 8'h00};
      vecs[9]  = '{1, 8'h01, 1, 1, 2'd1, 1, 3'd3, 0, 16'h4000, 0, 0, 16'h2004, 1, 0, 0, 8'h01};
      vecs[10] = '{0, 8'h00, 1, 0, 2'd1, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h2004, 0, 0, 0, 8'h01};
      vecs[11] = '{0, 8'h00, 1, 1, 2'd1, 1, 3'd3, 0, 16'h4000, 0, 0, 16'h4000, 1, 1, 0, 8'h01};
      vecs[12] = '{0, 8'h00, 0, 1, 2'd1, 0, 3'd0, 0, 16'h0000, 1, 0, 16'h4000, 0, 0, 1, 8'h01};
      vecs[13] = '{0, 8'h00, 1, 1, 2'd2, 0, 3'd0, 0, 16'h0000, 1, 1, 16'h4000, 0, 0, 1, 8'h01};
      vecs[14] = '{0, 8'h00, 0, 0, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 1, 16'h4000, 1, 0, 0, 8'h01};
      vecs[15] = '{0, 8'h00, 1, 0, 2'd2, 0, 3'd0, 0, 16'h0000, 1, 0, 16'h4000, 0, 0, 0, 8'h01};
      vecs[16] = '{0, 8'h00, 1, 1, 2'd0, 0, 3'd0, 0, 16'h0000, 1, 0, 16'h4001, 0, 0, 1, 8'h01};
      vecs[17] = '{0, 8'h00, 1, 0, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h4001, 0, 0, 1, 8'h01};
      vecs[18] = '{0, 8'h00, 1, 0, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 1, 16'h4001, 1, 0, 0, 8'h01};
      vecs[19] = '{0, 8'h00, 1, 0, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h4001, 0, 0, 0, 8'h01};
      vecs[20] = '{0, 8'h00, 1, 1, 2'd2, 1, 3'd0, 1, 16'h1234, 0, 0, 16'h1234, 1, 1, 0, 8'h01};
      vecs[21] = '{0, 8'h00, 1, 0, 2'd2, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h1234, 0, 0, 0, 8'h01};
      vecs[22] = '{0, 8'h00, 1, 1, 2'd2, 1, 3'd0, 0, 16'h5555, 0, 0, 16'h1236, 1, 0, 0, 8'h01};

      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      check("reset pc", 64'(bus.pc), 64'(RST_PC));
      check("reset flags", 64'(flags), 64'h00);
      check("reset jump_taken", 64'(jump_taken), 64'h0);
      check("reset halted", 64'(halted), 64'h0);
      check("fetch_valid in reset", 64'(bus.fetch_valid), 64'h0);
      rst = 1'b0;
      #1;
      check("fetch_valid after reset", 64'(bus.fetch_valid), 64'h1);

      foreach (vecs[i]) begin
         flags_we = vecs[i].fwe; flags_in = vecs[i].fin; bus.fetch_ready = vecs[i].rdy;
         retire = vecs[i].ret; instr_len = vecs[i].len; br_valid = vecs[i].bv;
         br_cond = vecs[i].bc; br_always = vecs[i].ba; br_target = vecs[i].tgt;
         halt_req = vecs[i].hr; resume = vecs[i].res;
         tick();
         check($sformatf("row%0d pc", i), 64'(bus.pc), 64'(vecs[i].e_pc));
         check($sformatf("row%0d fetch_valid", i), 64'(bus.fetch_valid), 64'(vecs[i].e_fv));
         check($sformatf("row%0d jump_taken", i), 64'(jump_taken), 64'(vecs[i].e_jt));
         check($sformatf("row%0d halted", i), 64'(halted), 64'(vecs[i].e_h));
         check($sformatf("row%0d flags", i), 64'(flags), 64'(vecs[i].e_fl));
      end

      // PC wrap: jump to FFFE, then retire a 3-byte instruction.
      idle_inputs(); bus.fetch_ready = 1'b1;
      tick();
      retire = 1'b1; br_valid = 1'b1; br_always = 1'b1; br_target = 16'hFFFE;
      tick();
      check("jump to fffe", 64'(bus.pc), 64'hFFFE);
      retire = 1'b0; br_valid = 1'b0;
      tick();
      retire = 1'b1; instr_len = 2'd3;
      tick();
      check("wrap pc", 64'(bus.pc), 64'h0001);
      check("wrap fetch_valid", 64'(bus.fetch_valid), 64'h1);

      // Reset mid-EXEC overrides a coincident retire.
      retire = 1'b0;
      tick();
      retire = 1'b1; instr_len = 2'd2; rst = 1'b1;
      tick();
      check("mid reset pc", 64'(bus.pc), 64'(RST_PC));
      check("mid reset fetch_valid", 64'(bus.fetch_valid), 64'h0);
      check("mid reset jump_taken", 64'(jump_taken), 64'h0);
      rst = 1'b0;
      #1;
      check("post reset fetch_valid", 64'(bus.fetch_valid), 64'h1);

      // Randomized phase against the model.
      idle_inputs();
      rst = 1'b1;
      model_edge();
      tick();
      rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         rst             = ($urandom_range(0, 199) == 0);
         bus.fetch_ready = ($urandom_range(0, 9) < 6);
         retire          = ($urandom_range(0, 1) == 1);
         instr_len       = 2'($urandom_range(0, 3));
         br_valid        = ($urandom_range(0, 1) == 1);
         br_cond         = 3'($urandom_range(0, 7));
         br_always       = ($urandom_range(0, 1) == 1);
         br_target       = 16'($urandom);
         halt_req        = ($urandom_range(0, 9) == 0);
         resume          = ($urandom_range(0, 9) < 3);
         flags_we        = ($urandom_range(0, 9) < 3);
         flags_in        = 8'($urandom);
         model_edge();
         tick();
         act = {bus.pc, bus.fetch_valid, jump_taken, halted, flags};
         exp = {16'(m_pc), (m_mode == M_WAIT) && !rst, m_jt, m_mode == M_STOP, m_flags};
         check($sformatf("random cycle %0d {pc,fv,jt,halted,flags}", n), 64'(act), 64'(exp));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter sequencer for the EightyTwos core. It owns the PC, the architectural flag register and the fetch/execute state machine. It issues instruction-fetch requests to memory over a valid/ready handshake and waits for the decoder to retire each instruction. On retire it either advances the PC by the instruction length or, for a conditional jump whose condition holds against the registered flags, loads the jump target. It sits between the instruction memory interface, the decoder/ALU and the jump condition logic.

## Interface
Parameters:
- ADDR_W, 16, PC / target width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- flags_in  in  8  ALU flag result; bit 0 C, bit 2 P, bit 6 Z, bit 7 S
- flags_we  in  1  load flags_in into the flag register
- fetch_valid  out  1  fetch request for address pc
- fetch_ready  in  1  memory accepts the fetch
- pc  out  ADDR_W  current program counter
- retire  in  1  decoder: current instruction complete
- instr_len  in  2  length of the retiring instruction in bytes (1–3; 0 is treated as 1)
- br_valid  in  1  retiring instruction is a jump
- br_cond  in  3  jump condition code
- br_always  in  1  unconditional-jump qualifier for code 000
- br_target  in  ADDR_W  jump destination
- halt_req  in  1  request to stop fetching
- resume  in  1  leave HALT
- halted  out  1  state == HALT
- jump_taken  out  1  one-cycle pulse: the PC was loaded from br_target
- flags  out  8  registered flag register

## Operation
- Reset values: state FETCH, pc=RESET_PC, flags=8'h00, jump_taken=0, halted=0. fetch_valid=0 while rst is high.
- Condition codes, evaluated on the registered flags:
  - 000: br_always
  - 001: Z
  - 010: ~C
  - 011: C
  - 100: ~P
  - 101: P
  - 110: S
  - 111: ~S
- FETCH:
  - fetch_valid=1.
  - fetch_valid & fetch_ready → EXEC.
  - Otherwise, if halt_req → HALT.
  - The handshake wins over a simultaneous halt_req; that halt is then honoured at the next retire.
- EXEC:
  - fetch_valid=0; wait for retire.
  - On retire with br_valid and the condition true: pc ← br_target, jump_taken=1 next cycle.
  - On any other retire: pc ← pc + instr_len, modulo 2^ADDR_W (wraps to 0).
  - After retire, next state is HALT if halt_req is high, else FETCH.
- HALT:
  - fetch_valid=0; pc and flags hold; flags_we still updates flags.
  - resume & ~halt_req → FETCH.
- flags_we is honoured in every state.
  - If flags_we coincides with a retire, the jump evaluates the old flag value.
  - The flag register takes the new value in the same edge.
- retire outside EXEC is ignored. br_valid without retire is ignored.
- rst asserted mid-operation overrides everything in that edge.

## Timing
- Fetch handshake completes on the posedge where fetch_valid & fetch_ready; EXEC begins the next cycle.
- retire sampled at posedge in EXEC:
  - new pc is visible the next cycle;
  - FETCH with the new pc is issued that same cycle;
  - jump_taken is registered and asserted that same cycle for exactly one cycle.
- Minimum throughput: 2 cycles per instruction (ready and retire each held high).
- pc is stable while fetch_valid is high and no handshake has completed.
- halted rises the cycle after the transition into HALT. FETCH resumes the cycle after resume is sampled.
- flags output updates one cycle after flags_we.

## Structure
- Package branch_pkg holds:
  - state enum {FETCH, EXEC, HALT};
  - condition-code localparams (COND_ALWAYS … COND_MINUS);
  - flag bit indices (FLAG_C=0, FLAG_P=2, FLAG_Z=6, FLAG_S=7).
- Sub-module cond_eval: purely combinational; flags[7:0], cond[2:0], always → take. Instantiated once.
- Top level contains the state register, PC register and adder, flag register, and jump_taken register.

## Test plan
- Reset with RESET_PC=16'h0100; fetch_ready=1; retire with instr_len=2 every EXEC → pc sequence 0100, 0102, 0104; jump_taken never asserted.
- flags_we with flags_in=8'h40, then retire with br_valid, br_cond=001, br_target=16'h2000 → pc=2000 next cycle, jump_taken pulses once. Repeat with flags=8'h00 → pc advances by instr_len instead.
- Same edge: flags_we with 8'h01 and retire with br_cond=011 while flags=8'h00 → not taken; flags reads 8'h01 next cycle.
- pc=16'hFFFE, retire with instr_len=3 → pc=16'h0001.
- halt_req in FETCH with fetch_ready=0 → HALT, halted=1, pc held. resume with halt_req low → FETCH the next cycle with the same pc.
- halt_req and fetch_ready in the same edge → EXEC. On retire the pc updates, the state enters HALT, and no further fetch_valid appears.
